pio_fifo_pair: RTL and testbench

//  Paired TX/RX FIFOs for one PIO state machine, with a shared storage array of 2*DEPTH words.

---
 rtl/pio_fifo_pkg.sv | 16 +
 rtl/pio_fifo_pair_if.sv | 38 +++
 rtl/pio_fifo_ctrl.sv | 76 +++++++
 rtl/pio_fifo_pair.sv | 122 ++++++++++++
 tb/tb_pio_fifo_pair.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/pio_fifo_pkg.sv
// rtl/pio_fifo_pkg.sv - join-mode encodings and level-width helper for the PIO FIFO pair
package pio_fifo_pkg;

    typedef enum logic [1:0] {
        MODE_NONE    = 2'b00,
        MODE_JOIN_TX = 2'b01,
        MODE_JOIN_RX = 2'b10,
        MODE_RSVD    = 2'b11
    } pio_mode_e;

    // Level must represent 0..2*DEPTH inclusive.
    function automatic int level_width(input int depth);
        return $clog2(2 * depth) + 1;
    endfunction

endpackage

// File: rtl/pio_fifo_pair_if.sv
// rtl/pio_fifo_pair_if.sv - TX/RX push/pull handshake bundle between bus side and FIFO pair
interface pio_fifo_pair_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    import pio_fifo_pkg::*;

    localparam int LW = level_width(DEPTH);

    logic             tx_push;
    logic [WIDTH-1:0] tx_din;
    logic             tx_pull;
    logic [WIDTH-1:0] tx_dout;
    logic             tx_empty;
    logic             tx_full;
    logic [LW-1:0]    tx_level;

    logic             rx_push;
    logic [WIDTH-1:0] rx_din;
    logic             rx_pull;
    logic [WIDTH-1:0] rx_dout;
    logic             rx_empty;
    logic             rx_full;
    logic [LW-1:0]    rx_level;

    modport master (
        output tx_push, tx_din, tx_pull, rx_push, rx_din, rx_pull,
        input  tx_dout, tx_empty, tx_full, tx_level,
        input  rx_dout, rx_empty, rx_full, rx_level
    );

    modport slave (
        input  tx_push, tx_din, tx_pull, rx_push, rx_din, rx_pull,
        output tx_dout, tx_empty, tx_full, tx_level,
        output rx_dout, rx_empty, rx_full, rx_level
    );

endinterface

// File: rtl/pio_fifo_ctrl.sv
// rtl/pio_fifo_ctrl.sv - per-channel head/tail/level bookkeeping with runtime capacity
// Optional sticky overflow/underflow flags when PIO_FIFO_STATUS_EN is defined.
module pio_fifo_ctrl #(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(2 * DEPTH) + 1,
    parameter int PW    = $clog2(2 * DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic [LW-1:0] cap,
    input  logic          push,
    input  logic          pull,
    output logic          push_ok,
    output logic          pull_ok,
    output logic [PW-1:0] head,
    output logic [PW-1:0] tail,
    output logic [LW-1:0] level,
    output logic          empty,
    output logic          full
`ifdef PIO_FIFO_STATUS_EN
    ,
    input  logic          status_clr,
    output logic          overflow,
    output logic          underflow
`endif
);

    // A zero-capacity channel is both empty and full, which blocks every operation.
    assign empty   = (level == '0);
    assign full    = (level == cap);
    assign pull_ok = pull && !empty && !flush;
    assign push_ok = push && (!full || pull_ok) && !flush;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] ptr,
                                               input logic [LW-1:0] lim);
        logic [LW-1:0] nxt;
        nxt = LW'(ptr) + LW'(1);
        return (nxt >= lim) ? '0 : nxt[PW-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            level <= '0;
        end else begin
            if (push_ok) tail <= wrap_inc(tail, cap);
            if (pull_ok) head <= wrap_inc(head, cap);
            case ({push_ok, pull_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

`ifdef PIO_FIFO_STATUS_EN
    logic ovf_set;
    logic udf_set;

    assign ovf_set = push && !push_ok && !flush;
    assign udf_set = pull && empty && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_set || (overflow && !status_clr);
            underflow <= udf_set || (underflow && !status_clr);
        end
    end
`endif

endmodule

// File: rtl/pio_fifo_pair.sv
// rtl/pio_fifo_pair.sv - paired TX/RX FIFOs over one shared 2*DEPTH array with join modes
// Define PIO_FIFO_STATUS_EN to add status_clr and sticky overflow/underflow flags.
module pio_fifo_pair
    import pio_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mode,
    pio_fifo_pair_if.slave       bus
`ifdef PIO_FIFO_STATUS_EN
    ,
    input  logic                 status_clr,
    output logic                 tx_overflow,
    output logic                 tx_underflow,
    output logic                 rx_overflow,
    output logic                 rx_underflow
`endif
);

    localparam int LW = level_width(DEPTH);
    localparam int PW = $clog2(2 * DEPTH);

    pio_mode_e     mode_q;
    logic          flush;
    logic [LW-1:0] cap_tx;
    logic [LW-1:0] cap_rx;
    logic [PW-1:0] rx_base;

    logic          tx_push_ok, tx_pull_ok, rx_push_ok, rx_pull_ok;
    logic [PW-1:0] tx_head, tx_tail, rx_head, rx_tail;

    logic [WIDTH-1:0] mem [2*DEPTH];

    assign flush = (mode != mode_q);

    always_ff @(posedge clk) begin
        if (reset || flush) mode_q <= pio_mode_e'(mode);
    end

    always_comb begin
        cap_tx  = LW'(DEPTH);
        cap_rx  = LW'(DEPTH);
        rx_base = PW'(DEPTH);
        case (mode_q)
            MODE_JOIN_TX: begin
                cap_tx  = LW'(2 * DEPTH);
                cap_rx  = '0;
                rx_base = '0;
            end
            MODE_JOIN_RX: begin
                cap_tx  = '0;
                cap_rx  = LW'(2 * DEPTH);
                rx_base = '0;
            end
            default: ;
        endcase
    end

    pio_fifo_ctrl #(.DEPTH(DEPTH), .LW(LW), .PW(PW)) u_tx (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .cap     (cap_tx),
        .push    (bus.tx_push),
        .pull    (bus.tx_pull),
        .push_ok (tx_push_ok),
        .pull_ok (tx_pull_ok),
        .head    (tx_head),
        .tail    (tx_tail),
        .level   (bus.tx_level),
        .empty   (bus.tx_empty),
        .full    (bus.tx_full)
`ifdef PIO_FIFO_STATUS_EN
        ,
        .status_clr (status_clr),
        .overflow   (tx_overflow),
        .underflow  (tx_underflow)
`endif
    );

    pio_fifo_ctrl #(.DEPTH(DEPTH), .LW(LW), .PW(PW)) u_rx (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .cap     (cap_rx),
        .push    (bus.rx_push),
        .pull    (bus.rx_pull),
        .push_ok (rx_push_ok),
        .pull_ok (rx_pull_ok),
        .head    (rx_head),
        .tail    (rx_tail),
        .level   (bus.rx_level),
        .empty   (bus.rx_empty),
        .full    (bus.rx_full)
`ifdef PIO_FIFO_STATUS_EN
        ,
        .status_clr (status_clr),
        .overflow   (rx_overflow),
        .underflow  (rx_underflow)
`endif
    );

    // TX always starts at 0; only one channel has capacity in join mode, so writes never collide.
    always_ff @(posedge clk) begin
        if (tx_push_ok) mem[tx_tail] <= bus.tx_din;
        if (rx_push_ok) mem[rx_base + rx_tail] <= bus.rx_din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.tx_dout <= '0;
            bus.rx_dout <= '0;
        end else begin
            if (tx_pull_ok) bus.tx_dout <= mem[tx_head];
            if (rx_pull_ok) bus.rx_dout <= mem[rx_base + rx_head];
        end
    end

endmodule

// File: tb/tb_pio_fifo_pair.sv
// tb/tb_pio_fifo_pair.sv - directed and randomized checks of pio_fifo_pair against a queue model
module tb_pio_fifo_pair;
    import pio_fifo_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;

    always #5 clk = ~clk;

    pio_fifo_pair_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

`ifdef PIO_FIFO_STATUS_EN
    logic status_clr;
    logic tx_overflow, tx_underflow, rx_overflow, rx_underflow;
`endif

    pio_fifo_pair #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .bus   (bus)
`ifdef PIO_FIFO_STATUS_EN
        ,
        .status_clr   (status_clr),
        .tx_overflow  (tx_overflow),
        .tx_underflow (tx_underflow),
        .rx_overflow  (rx_overflow),
        .rx_underflow (rx_underflow)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] txq[$];
    logic [31:0] rxq[$];
    logic [31:0] m_tx_dout, m_rx_dout;
    logic [1:0]  m_mode;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cap_of(input bit is_tx);
        case (m_mode)
            2'b01:   return is_tx ? 2 * DEPTH : 0;
            2'b10:   return is_tx ? 0 : 2 * DEPTH;
            default: return DEPTH;
        endcase
    endfunction

    task automatic model_step();
        bit pl, ps;
        if (reset) begin
            txq.delete(); rxq.delete();
            m_tx_dout = '0; m_rx_dout = '0;
            m_mode = mode;
        end else if (mode != m_mode) begin
            txq.delete(); rxq.delete();
            m_mode = mode;
        end else begin
            pl = bus.tx_pull && txq.size() != 0;
            ps = bus.tx_push && (txq.size() < cap_of(1) || pl);
            if (pl) m_tx_dout = txq.pop_front();
            if (ps) txq.push_back(bus.tx_din);
            pl = bus.rx_pull && rxq.size() != 0;
            ps = bus.rx_push && (rxq.size() < cap_of(0) || pl);
            if (pl) m_rx_dout = rxq.pop_front();
            if (ps) rxq.push_back(bus.rx_din);
        end
    endtask

    task automatic check_all();
        check("tx_dout",  64'(bus.tx_dout),  64'(m_tx_dout));
        check("tx_level", 64'(bus.tx_level), 64'(txq.size()));
        check("tx_empty", 64'(bus.tx_empty), 64'(txq.size() == 0));
        check("tx_full",  64'(bus.tx_full),  64'(txq.size() == cap_of(1)));
        check("rx_dout",  64'(bus.rx_dout),  64'(m_rx_dout));
        check("rx_level", 64'(bus.rx_level), 64'(rxq.size()));
        check("rx_empty", 64'(bus.rx_empty), 64'(rxq.size() == 0));
        check("rx_full",  64'(bus.rx_full),  64'(rxq.size() == cap_of(0)));
    endtask

    task automatic drive(input bit tp, input logic [31:0] td, input bit tl,
                         input bit rp, input logic [31:0] rd, input bit rl);
        bus.tx_push = tp; bus.tx_din = td; bus.tx_pull = tl;
        bus.rx_push = rp; bus.rx_din = rd; bus.rx_pull = rl;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_cycle();
        drive(0, 0, 0, 0, 0, 0);
        cycle();
    endtask

    logic [31:0] exp_seq[$];
    logic [31:0] saved;

    initial begin
`ifdef PIO_FIFO_STATUS_EN
        status_clr = 1'b0;
`endif
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        mode  = 2'b00;
        #2;
        cycle();
        check("rst_tx_empty", 64'(bus.tx_empty), 64'd1);
        check("rst_rx_level", 64'(bus.rx_level), 64'd0);
        check("rst_tx_dout",  64'(bus.tx_dout),  64'd0);
        reset = 1'b0;
        idle_cycle();

        // 1: fill TX, overflow, drain in order
        for (int i = 1; i <= 4; i++) begin drive(1, i, 0, 0, 0, 0); cycle(); end
        check("t1_full",  64'(bus.tx_full),  64'd1);
        check("t1_level", 64'(bus.tx_level), 64'd4);
        drive(1, 5, 0, 0, 0, 0); cycle();
        check("t1_drop_level", 64'(bus.tx_level), 64'd4);
`ifdef PIO_FIFO_STATUS_EN
        check("t1_overflow", 64'(tx_overflow), 64'd1);
`endif
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 1, 0, 0, 0); cycle();
            check("t1_dout", 64'(bus.tx_dout), 64'(i));
        end
        check("t1_empty", 64'(bus.tx_empty), 64'd1);

        // 2: join TX
        mode = 2'b01; idle_cycle();
        for (int i = 0; i < 8; i++) begin drive(1, 32'hA0 + i, 0, 0, 0, 0); cycle(); end
        check("t2_level", 64'(bus.tx_level), 64'd8);
        check("t2_full",  64'(bus.tx_full),  64'd1);
        check("t2_rx_empty", 64'(bus.rx_empty), 64'd1);
        check("t2_rx_full",  64'(bus.rx_full),  64'd1);
        drive(0, 0, 0, 1, 32'h55, 0); cycle();
        check("t2_rx_ignored", 64'(bus.rx_level), 64'd0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, 0, 0, 0); cycle();
            check("t2_dout", 64'(bus.tx_dout), 64'(32'hA0 + i));
        end

        // 3: steady-state push+pull at level 2 across the wrap
        mode = 2'b00; idle_cycle();
        drive(1, 32'h100, 0, 0, 0, 0); cycle();
        drive(1, 32'h101, 0, 0, 0, 0); cycle();
        exp_seq = '{32'h100, 32'h101};
        for (int i = 0; i < 10; i++) begin
            exp_seq.push_back(10 + i);
            drive(1, 10 + i, 1, 0, 0, 0); cycle();
            check("t3_level", 64'(bus.tx_level), 64'd2);
            check("t3_dout", 64'(bus.tx_dout), 64'(exp_seq[i]));
        end

        // 4: push+pull on full TX, on empty RX
        drive(1, 32'h200, 0, 0, 0, 0); cycle();
        drive(1, 32'h201, 0, 0, 0, 0); cycle();
        check("t4_full", 64'(bus.tx_full), 64'd1);
        saved = 18;
        drive(1, 32'h202, 1, 0, 0, 0); cycle();
        check("t4_level", 64'(bus.tx_level), 64'd4);
        check("t4_oldest", 64'(bus.tx_dout), 64'(saved));
        saved = m_rx_dout;
        drive(0, 0, 0, 1, 32'h300, 1); cycle();
        check("t4_rx_level", 64'(bus.rx_level), 64'd1);
        check("t4_rx_dout",  64'(bus.rx_dout),  64'(saved));

        // 5: mode change flushes and ignores that cycle's traffic
        while (txq.size() > 0) begin drive(0, 0, 1, 0, 0, 0); cycle(); end
        for (int i = 0; i < 3; i++) begin drive(1, 32'h400 + i, 0, 0, 0, 0); cycle(); end
        check("t5_pre_level", 64'(bus.tx_level), 64'd3);
        mode = 2'b10;
        drive(1, 32'h4FF, 1, 1, 32'h4FE, 1); cycle();
        check("t5_tx_flush", 64'(bus.tx_level), 64'd0);
        check("t5_rx_flush", 64'(bus.rx_level), 64'd0);
        for (int i = 0; i < 8; i++) begin drive(0, 0, 0, 1, 32'h500 + i, 0); cycle(); end
        check("t5_rx_level", 64'(bus.rx_level), 64'd8);

        // 6: mid-stream reset
        mode = 2'b00; idle_cycle();
        for (int i = 0; i < 3; i++) begin drive(1, 32'h600 + i, 0, i < 2, 32'h610 + i, 0); cycle(); end
        drive(0, 0, 1, 0, 0, 1); cycle();
        reset = 1'b1;
        drive(1, 32'h6FF, 1, 1, 32'h6FE, 1); cycle();
        reset = 1'b0;
        check("t6_tx_level", 64'(bus.tx_level), 64'd0);
        check("t6_rx_level", 64'(bus.rx_level), 64'd0);
        check("t6_tx_dout",  64'(bus.tx_dout),  64'd0);
`ifdef PIO_FIFO_STATUS_EN
        check("t6_flags", 64'({tx_overflow, tx_underflow, rx_overflow, rx_underflow}), 64'd0);
`endif
        drive(1, 32'hBEEF, 0, 0, 0, 0); cycle();
        drive(0, 0, 1, 0, 0, 0); cycle();
        check("t6_readback", 64'(bus.tx_dout), 64'h0000BEEF);

        // Randomized traffic with occasional mode changes and resets
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
            drive($urandom_range(0, 1), $urandom, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1), $urandom, $urandom_range(0, 2) == 0);
            if (i % 300 > 150) begin bus.tx_pull = $urandom_range(0, 1); bus.rx_pull = $urandom_range(0, 1); end
            cycle();
        end
        reset = 1'b0;
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
